hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the execute stage. It generates the execute-stage operand forwarding selects, detects load-use hazards, and flushes on branch mispredicts (wrong_branch from execute). It also runs the stall handshake for a multi-cycle execute unit (mul/div) and keeps saturating stall/flush performance counters. It sits beside the F/D/E/M/W pipeline registers and drives their stall and flush controls.

---
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Hazard controller for the execute stage of a five-stage pipeline.
//   - Selects execute-stage operand forwarding sources (M has priority over W,
//     x0 is never forwarded).
//   - Detects load-use hazards and inserts a single bubble into ID/EX.
//   - Flushes IF/ID and ID/EX on an execute-stage redirect.
//   - Runs the start/stall/done handshake with a multi-cycle unit (mul/div),
//     with a timeout abort.
//   - Keeps saturating counts of stalled cycles and of redirect flushes.
//
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   rs1D/rs2D_addr_i         decode-stage source registers
//   rs1E/rs2E/rdE_addr_i     execute-stage source and destination registers
//   loadE_i                  execute-stage instruction is a load
//   rdM_addr_i/rdM_wr_ena_i  memory-stage destination and write enable
//   rdW_addr_i/rdW_wr_ena_i  writeback-stage destination and write enable
//   wrong_branch_i           execute-stage redirect / mispredict
//   mcE_req_i, mc_done_i     multi-cycle request and result-valid pulse
//   forwardAE_o/forwardBE_o  operand selects: 00 regfile, 01 W, 10 M
//   stallF/D/E_o             hold PC, IF/ID, ID/EX
//   flushD/E/M_o             bubble IF/ID, ID/EX, EX/MEM
//   mc_start_o, mc_err_o     start pulse and timeout pulse
//   stall_cnt_o, flush_cnt_o saturating performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [4:0]       rs1D_addr_i,
    input  logic [4:0]       rs2D_addr_i,
    input  logic [4:0]       rs1E_addr_i,
    input  logic [4:0]       rs2E_addr_i,
    input  logic [4:0]       rdE_addr_i,
    input  logic             loadE_i,
    input  logic [4:0]       rdM_addr_i,
    input  logic             rdM_wr_ena_i,
    input  logic [4:0]       rdW_addr_i,
    input  logic             rdW_wr_ena_i,
    input  logic             wrong_branch_i,
    input  logic             mcE_req_i,
    input  logic             mc_done_i,
    output logic [1:0]       forwardAE_o,
    output logic [1:0]       forwardBE_o,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             stallE_o,
    output logic             flushD_o,
    output logic             flushE_o,
    output logic             flushM_o,
    output logic             mc_start_o,
    output logic             mc_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Timer counts completed MC_WAIT cycles; it never exceeds MC_TIMEOUT-1.
    localparam int TMR_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [CNT_W-1:0]   flush_cnt_reg;

    // ------------------------------------------------------------------
    // Forwarding: one identical select per execute-stage source operand.
    // ------------------------------------------------------------------
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd_sel;

    assign rs_e[0] = rs1E_addr_i;
    assign rs_e[1] = rs2E_addr_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m;
            logic hit_w;
            assign hit_m = rdM_wr_ena_i && (rdM_addr_i != 5'd0) && (rdM_addr_i == rs_e[gi]);
            assign hit_w = rdW_wr_ena_i && (rdW_addr_i != 5'd0) && (rdW_addr_i == rs_e[gi]);
            assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
        end
    endgenerate

    assign forwardAE_o = fwd_sel[0];
    assign forwardBE_o = fwd_sel[1];

    // ------------------------------------------------------------------
    // Control: outputs are combinational from state and inputs so that a
    // hazard is answered in the same cycle it is seen.
    // ------------------------------------------------------------------
    logic load_use;
    logic timeout;

    assign load_use = loadE_i && (rdE_addr_i != 5'd0) &&
                      ((rdE_addr_i == rs1D_addr_i) || (rdE_addr_i == rs2D_addr_i));

    // Last permitted wait cycle: the MC_TIMEOUT-th cycle after mc_start_o.
    assign timeout = (timer_reg == TMR_W'(MC_TIMEOUT - 1));

    always_comb begin
        stallF_o   = 1'b0;
        stallD_o   = 1'b0;
        stallE_o   = 1'b0;
        flushD_o   = 1'b0;
        flushE_o   = 1'b0;
        flushM_o   = 1'b0;
        mc_start_o = 1'b0;
        mc_err_o   = 1'b0;
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            RUN: begin
                if (wrong_branch_i) begin
                    flushD_o = 1'b1;
                    flushE_o = 1'b1;
                end else if (mcE_req_i) begin
                    mc_start_o = 1'b1;
                    stallF_o   = 1'b1;
                    stallD_o   = 1'b1;
                    stallE_o   = 1'b1;
                    flushM_o   = 1'b1;
                    state_next = MC_WAIT;
                    timer_next = '0;
                end else if (load_use) begin
                    // The load moves on to M next cycle, so this lasts one cycle.
                    stallF_o = 1'b1;
                    stallD_o = 1'b1;
                    flushE_o = 1'b1;
                end
            end
            MC_WAIT: begin
                if (mc_done_i) begin
                    // Release the pipe so the result is captured into EX/MEM.
                    state_next = RUN;
                end else if (timeout) begin
                    mc_err_o   = 1'b1;
                    state_next = RUN;
                end else begin
                    stallF_o   = 1'b1;
                    stallD_o   = 1'b1;
                    stallE_o   = 1'b1;
                    flushM_o   = 1'b1;
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, timer and saturating counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg     <= RUN;
            timer_reg     <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            if (stallF_o && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flushD_o && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Drives hazard_ctrl with directed scenarios followed by random traffic and
// compares every output, every cycle, against a cycle-counting reference
// model. A short timeout and narrow counters let the timeout and saturation
// corners be reached quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MC_TO   = 6;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic [4:0]       rs1D_addr_i, rs2D_addr_i, rs1E_addr_i, rs2E_addr_i, rdE_addr_i;
    logic             loadE_i;
    logic [4:0]       rdM_addr_i, rdW_addr_i;
    logic             rdM_wr_ena_i, rdW_wr_ena_i;
    logic             wrong_branch_i, mcE_req_i, mc_done_i;
    logic [1:0]       forwardAE_o, forwardBE_o;
    logic             stallF_o, stallD_o, stallE_o;
    logic             flushD_o, flushE_o, flushM_o;
    logic             mc_start_o, mc_err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit m_known       = 0;  // model valid once a reset has been applied
    bit m_wait        = 0;  // waiting on the multi-cycle unit
    int m_wait_cycles = 0;  // wait cycles already completed
    int m_stalls      = 0;
    int m_flushes     = 0;

    hazard_ctrl #(
        .MC_TIMEOUT (MC_TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .rs1D_addr_i    (rs1D_addr_i),
        .rs2D_addr_i    (rs2D_addr_i),
        .rs1E_addr_i    (rs1E_addr_i),
        .rs2E_addr_i    (rs2E_addr_i),
        .rdE_addr_i     (rdE_addr_i),
        .loadE_i        (loadE_i),
        .rdM_addr_i     (rdM_addr_i),
        .rdM_wr_ena_i   (rdM_wr_ena_i),
        .rdW_addr_i     (rdW_addr_i),
        .rdW_wr_ena_i   (rdW_wr_ena_i),
        .wrong_branch_i (wrong_branch_i),
        .mcE_req_i      (mcE_req_i),
        .mc_done_i      (mc_done_i),
        .forwardAE_o    (forwardAE_o),
        .forwardBE_o    (forwardBE_o),
        .stallF_o       (stallF_o),
        .stallD_o       (stallD_o),
        .stallE_o       (stallE_o),
        .flushD_o       (flushD_o),
        .flushE_o       (flushE_o),
        .flushM_o       (flushM_o),
        .mc_start_o     (mc_start_o),
        .mc_err_o       (mc_err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rdM_wr_ena_i && rdM_addr_i != 0 && rdM_addr_i == rs) return 2'b10;
        if (rdW_wr_ena_i && rdW_addr_i != 0 && rdW_addr_i == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rs1D_addr_i = 0; rs2D_addr_i = 0; rs1E_addr_i = 0; rs2E_addr_i = 0;
        rdE_addr_i = 0; loadE_i = 0; rdM_addr_i = 0; rdM_wr_ena_i = 0;
        rdW_addr_i = 0; rdW_wr_ena_i = 0; wrong_branch_i = 0;
        mcE_req_i = 0; mc_done_i = 0;
    endtask

    // Called just after a falling edge with inputs applied: compares all
    // outputs with the model, advances the model, returns at the next
    // falling edge.
    task automatic tick();
        bit sf, se, fd, fe, fm, st, er, lu;
        int k;
        #1;
        sf = 0; se = 0; fd = 0; fe = 0; fm = 0; st = 0; er = 0; k = 0;
        lu = loadE_i && rdE_addr_i != 0 &&
             (rdE_addr_i == rs1D_addr_i || rdE_addr_i == rs2D_addr_i);
        if (!m_wait) begin
            if (wrong_branch_i) begin
                fd = 1; fe = 1;
            end else if (mcE_req_i) begin
                st = 1; sf = 1; se = 1; fm = 1;
            end else if (lu) begin
                sf = 1; fe = 1;
            end
        end else begin
            k = m_wait_cycles + 1;
            if (mc_done_i) begin
                // result accepted, nothing held
            end else if (k == MC_TO) begin
                er = 1;
            end else begin
                sf = 1; se = 1; fm = 1;
            end
        end

        check("fwdA", forwardAE_o, fwd_model(rs1E_addr_i));
        check("fwdB", forwardBE_o, fwd_model(rs2E_addr_i));
        if (m_known) begin
            check("stallF", stallF_o, sf);
            check("stallD", stallD_o, sf);
            check("stallE", stallE_o, se);
            check("flushD", flushD_o, fd);
            check("flushE", flushE_o, fe);
            check("flushM", flushM_o, fm);
            check("mc_start", mc_start_o, st);
            check("mc_err", mc_err_o, er);
            check("stall_cnt", stall_cnt_o, m_stalls);
            check("flush_cnt", flush_cnt_o, m_flushes);
        end
        $display("tb cyc=%0d rstn=%0d wait=%0d sf=%0d fd=%0d fm=%0d st=%0d er=%0d sc=%0d fc=%0d",
                 cyc, rstn_i, m_wait, stallF_o, flushD_o, flushM_o, mc_start_o, mc_err_o,
                 stall_cnt_o, flush_cnt_o);

        if (!rstn_i) begin
            m_known = 1; m_wait = 0; m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_known) begin
            if (sf && m_stalls < CNT_MAX) m_stalls++;
            if (fd && m_flushes < CNT_MAX) m_flushes++;
            if (!m_wait) begin
                if (!wrong_branch_i && mcE_req_i) begin
                    m_wait = 1; m_wait_cycles = 0;
                end
            end else if (mc_done_i || k == MC_TO) begin
                m_wait = 0;
            end else begin
                m_wait_cycles++;
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        idle();
        rstn_i = 0;
        @(negedge clk_i);
        tick();
        rstn_i = 1;

        // Post-reset idle
        #1;
        check("rst_stall_cnt", stall_cnt_o, 0);
        check("rst_flush_cnt", flush_cnt_o, 0);
        check("rst_stallF", stallF_o, 0);
        tick();

        // Forwarding priority
        rs1E_addr_i = 5; rdM_addr_i = 5; rdM_wr_ena_i = 1; rdW_addr_i = 5; rdW_wr_ena_i = 1;
        #1; check("fwd_m_prio", forwardAE_o, 2'b10); tick();
        rdM_wr_ena_i = 0;
        #1; check("fwd_w", forwardAE_o, 2'b01); tick();
        rs1E_addr_i = 0; rdM_addr_i = 0; rdM_wr_ena_i = 1;
        #1; check("fwd_x0", forwardAE_o, 2'b00); tick();

        // Load-use
        idle(); loadE_i = 1; rdE_addr_i = 7; rs2D_addr_i = 7;
        #1; check("lu_stallF", stallF_o, 1); check("lu_flushE", flushE_o, 1); tick();
        idle();
        #1; check("lu_release", stallF_o, 0); check("lu_cnt", stall_cnt_o, 1); tick();

        // Mispredict together with load-use
        wrong_branch_i = 1; loadE_i = 1; rdE_addr_i = 7; rs2D_addr_i = 7;
        #1; check("wb_flushD", flushD_o, 1); check("wb_nostall", stallF_o, 0); tick();
        idle();
        #1; check("wb_cnt", flush_cnt_o, 1); tick();

        // Multi-cycle with done at T5
        mcE_req_i = 1;
        #1; check("mc_start_t0", mc_start_o, 1); tick();
        mcE_req_i = 0;
        for (int i = 1; i <= 4; i++) tick();
        mc_done_i = 1;
        #1; check("mc_done_stall", stallF_o, 0); check("mc_done_flushM", flushM_o, 0); tick();
        mc_done_i = 0;
        #1; check("mc_stall_cnt", stall_cnt_o, 6); tick();

        // Timeout without done
        mcE_req_i = 1; tick();
        mcE_req_i = 0;
        for (int i = 1; i < MC_TO; i++) tick();
        #1; check("to_err", mc_err_o, 1); check("to_stall", stallF_o, 0); tick();
        #1; check("to_after_err", mc_err_o, 0); check("to_after_stall", stallF_o, 0); tick();

        // Done on the timeout cycle
        mcE_req_i = 1; tick();
        mcE_req_i = 0;
        for (int i = 1; i < MC_TO; i++) tick();
        mc_done_i = 1;
        #1; check("coinc_err", mc_err_o, 0); tick();
        mc_done_i = 0;

        // Reset mid-wait
        mcE_req_i = 1; tick();
        mcE_req_i = 0; tick();
        rstn_i = 0; tick();
        rstn_i = 1;
        #1;
        check("mrst_stall", stallF_o, 0);
        check("mrst_scnt", stall_cnt_o, 0);
        check("mrst_fcnt", flush_cnt_o, 0);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rstn_i         = ($urandom_range(0, 99) != 0);
            rs1D_addr_i    = 5'($urandom_range(0, 3));
            rs2D_addr_i    = 5'($urandom_range(0, 3));
            rs1E_addr_i    = 5'($urandom_range(0, 3));
            rs2E_addr_i    = 5'($urandom_range(0, 3));
            rdE_addr_i     = 5'($urandom_range(0, 3));
            rdM_addr_i     = 5'($urandom_range(0, 3));
            rdW_addr_i     = 5'($urandom_range(0, 3));
            rdM_wr_ena_i   = 1'($urandom_range(0, 1));
            rdW_wr_ena_i   = 1'($urandom_range(0, 1));
            loadE_i        = ($urandom_range(0, 2) == 0);
            wrong_branch_i = ($urandom_range(0, 5) == 0);
            mcE_req_i      = ($urandom_range(0, 5) == 0);
            mc_done_i      = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
